// File: rtl/pc_next_ctrl.sv
// Next-PC controller: selects the next program counter source, defers a
// redirect that resolves while fetch is busy or stalled, and tracks a sticky
// halt plus a saturating count of applied redirects.
module pc_next_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      pc,
  input  logic             ihit,
  input  logic             stall,
  input  logic             jmp_req,
  input  logic             jr_req,
  input  logic             br_taken,
  input  logic [25:0]      jaddr,
  input  logic [15:0]      imm16,
  input  logic [31:0]      rdat1_in,
  input  logic             halt_in,
  output logic             updatePC,
  output logic [1:0]       pcSel,
  output logic [31:0]      npc,
  output logic [31:0]      jump,
  output logic [31:0]      rdat1,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HOLD = 2'b01,
    S_HALT = 2'b10
  } state_e;

  localparam logic [1:0] SEL_NPC  = 2'b00;
  localparam logic [1:0] SEL_JUMP = 2'b01;
  localparam logic [1:0] SEL_RDAT = 2'b10;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pend_q, pend_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  npc_w, jtgt_w, btgt_w, req_tgt_w, jump_w;
  logic             upd_w, go_w, req_any_w;
  logic [1:0]       sel_w;

  // Target arithmetic shared by the immediate and deferred redirect paths
  always_comb begin
    npc_w     = pc + XLEN'(4);
    jtgt_w    = {npc_w[31:28], jaddr, 2'b00};
    btgt_w    = npc_w + {{14{imm16[15]}}, imm16, 2'b00};
    req_any_w = jr_req | jmp_req | br_taken;
    go_w      = ihit & ~stall;
    if (jr_req)       req_tgt_w = rdat1_in;
    else if (jmp_req) req_tgt_w = jtgt_w;
    else              req_tgt_w = btgt_w;
  end

  // Next-state and output decode; RST forces the PC load off
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    halted_d = halted_q;
    upd_w    = 1'b0;
    sel_w    = SEL_NPC;
    jump_w   = jmp_req ? jtgt_w : btgt_w;
    unique case (state_q)
      S_RUN: begin
        if (halt_in) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (go_w) begin
          upd_w = 1'b1;
          if (jr_req)                   sel_w = SEL_RDAT;
          else if (jmp_req || br_taken) sel_w = SEL_JUMP;
          else                          sel_w = SEL_NPC;
        end else if (req_any_w) begin
          pend_d  = req_tgt_w;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        sel_w  = SEL_JUMP;
        jump_w = pend_q;
        if (halt_in) begin
          pend_d   = '0;
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (go_w) begin
          upd_w   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        jump_w = '0;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    if (RST) begin
      upd_w = 1'b0;
      sel_w = SEL_NPC;
    end
  end

  // Saturating count of cycles that load a non-sequential PC
  always_comb begin
    cnt_d = cnt_q;
    if (upd_w && (sel_w != SEL_NPC) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, pending target, halt flag and counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_RUN;
      pend_q   <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign updatePC     = upd_w;
  assign pcSel        = sel_w;
  assign npc          = npc_w;
  assign jump         = jump_w;
  assign rdat1        = rdat1_in;
  assign halted       = halted_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Bench for pc_next_ctrl: directed vectors, a cycle-level reference model
// checked every cycle, and literal spot checks on key results.
module tb_pc_next_ctrl;

  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [31:0]      pc = '0;
  logic             ihit = 1'b0, stall = 1'b0;
  logic             jmp_req = 1'b0, jr_req = 1'b0, br_taken = 1'b0;
  logic [25:0]      jaddr = '0;
  logic [15:0]      imm16 = '0;
  logic [31:0]      rdat1_in = '0;
  logic             halt_in = 1'b0;
  logic             updatePC;
  logic [1:0]       pcSel;
  logic [31:0]      npc, jump, rdat1;
  logic             halted;
  logic [CNT_W-1:0] redirect_cnt;

  int errors = 0;
  int checks = 0;

  pc_next_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .pc(pc), .ihit(ihit), .stall(stall),
    .jmp_req(jmp_req), .jr_req(jr_req), .br_taken(br_taken),
    .jaddr(jaddr), .imm16(imm16), .rdat1_in(rdat1_in), .halt_in(halt_in),
    .updatePC(updatePC), .pcSel(pcSel), .npc(npc), .jump(jump),
    .rdat1(rdat1), .halted(halted), .redirect_cnt(redirect_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: mode 0 running, 1 holding a redirect, 2 halted
  int          m_mode = 0;
  logic [31:0] m_pend = '0;
  logic        m_halted = 1'b0;
  int          m_cnt = 0;

  logic [31:0] e_npc, e_jt, e_bt, e_jump;
  logic        e_upd, e_jchk, e_go;
  logic [1:0]  e_sel;

  always_comb begin
    e_npc  = pc + 32'd4;
    e_jt   = (e_npc & 32'hF000_0000) | (32'(jaddr) * 32'd4);
    e_bt   = e_npc + 32'($signed(imm16)) * 32'd4;
    e_go   = ihit && !stall;
    e_upd  = 1'b0;
    e_sel  = 2'd0;
    e_jump = '0;
    e_jchk = 1'b0;
    if (m_mode == 0) begin
      if (!halt_in && e_go) begin
        e_upd = 1'b1;
        if (jr_req) e_sel = 2'd2;
        else if (jmp_req || br_taken) begin
          e_sel  = 2'd1;
          e_jump = jmp_req ? e_jt : e_bt;
          e_jchk = 1'b1;
        end
      end
    end else if (m_mode == 1) begin
      e_sel  = 2'd1;
      e_jump = m_pend;
      e_jchk = 1'b1;
      e_upd  = e_go && !halt_in;
    end else begin
      e_jchk = 1'b1;
    end
    if (RST) begin
      e_upd = 1'b0;
      e_sel = 2'd0;
    end
  end

  // Advance the model on each rising edge
  always @(posedge CLK) begin
    if (RST) begin
      m_mode = 0; m_pend = '0; m_halted = 1'b0; m_cnt = 0;
    end else begin
      if (e_upd && e_sel != 2'd0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (m_mode == 0) begin
        if (halt_in) begin
          m_mode = 2; m_halted = 1'b1;
        end else if (!e_go && (jr_req || jmp_req || br_taken)) begin
          m_mode = 1;
          m_pend = jr_req ? rdat1_in : (jmp_req ? e_jt : e_bt);
        end
      end else if (m_mode == 1) begin
        if (halt_in) begin
          m_mode = 2; m_halted = 1'b1; m_pend = '0;
        end else if (e_go) begin
          m_mode = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    chk("m_updatePC", 32'(updatePC), 32'(e_upd));
    chk("m_npc", npc, e_npc);
    chk("m_rdat1", rdat1, rdat1_in);
    chk("m_halted", 32'(halted), 32'(m_halted));
    chk("m_cnt", 32'(redirect_cnt), 32'(m_cnt));
    if (e_upd || m_mode != 0 || RST) chk("m_pcSel", 32'(pcSel), 32'(e_sel));
    if (e_jchk && !RST) chk("m_jump", jump, e_jump);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_req();
    jmp_req = 1'b0; jr_req = 1'b0; br_taken = 1'b0; halt_in = 1'b0; stall = 1'b0;
  endtask

  initial begin
    // Reset cycle
    #2 chk("rst_upd", 32'(updatePC), 32'd0);
    chk("rst_sel", 32'(pcSel), 32'd0);
    step();
    RST = 1'b0;

    // Sequential fetch
    pc = 32'h100; ihit = 1'b1;
    #2 chk("seq_npc", npc, 32'h104);
    chk("seq_upd", 32'(updatePC), 32'd1);
    chk("seq_sel", 32'(pcSel), 32'd0);
    chk("seq_cnt", 32'(redirect_cnt), 32'd0);
    step();

    // Jump
    pc = 32'h0040_0010; jmp_req = 1'b1; jaddr = 26'h40;
    #2 chk("j_tgt", jump, 32'h100);
    chk("j_sel", 32'(pcSel), 32'd1);
    step();
    chk("j_cnt", 32'(redirect_cnt), 32'd1);

    // Branch with negative offset
    clr_req(); pc = 32'h200; br_taken = 1'b1; imm16 = 16'hFFFE;
    #2 chk("br_tgt", jump, 32'h1FC);
    step();

    // Wrapping npc
    clr_req(); pc = 32'hFFFF_FFFC;
    #2 chk("wrap_npc", npc, 32'h0);
    step();

    // Deferred JR
    jr_req = 1'b1; rdat1_in = 32'h3000; ihit = 1'b0; pc = 32'h500;
    #2 chk("djr_upd0", 32'(updatePC), 32'd0);
    step();
    clr_req(); jmp_req = 1'b1; jaddr = 26'h123; stall = 1'b1; ihit = 1'b1;
    #2 chk("djr_hold_upd", 32'(updatePC), 32'd0);
    chk("djr_hold_tgt", jump, 32'h3000);
    step();
    clr_req(); ihit = 1'b1;
    #2 chk("djr_apply_upd", 32'(updatePC), 32'd1);
    chk("djr_apply_sel", 32'(pcSel), 32'd1);
    chk("djr_apply_tgt", jump, 32'h3000);
    step();

    // Priority: JR beats jump and branch
    jr_req = 1'b1; jmp_req = 1'b1; br_taken = 1'b1; ihit = 1'b1;
    #2 chk("prio_sel", 32'(pcSel), 32'd2);
    step();

    // Reset while holding drops the redirect and clears the counter
    clr_req(); jmp_req = 1'b1; ihit = 1'b0;
    step();
    clr_req(); RST = 1'b1;
    #2 chk("rsthold_upd", 32'(updatePC), 32'd0);
    step();
    RST = 1'b0; ihit = 1'b0;
    #2 chk("rsthold_halted", 32'(halted), 32'd0);
    chk("rsthold_cnt", 32'(redirect_cnt), 32'd0);
    step();
    ihit = 1'b1;
    #2 chk("rsthold_run_sel", 32'(pcSel), 32'd0);
    step();

    // Saturation after five applied jumps
    for (int i = 0; i < 5; i++) begin
      jmp_req = 1'b1; jaddr = 26'(i); ihit = 1'b1;
      step();
    end
    clr_req();
    #2 chk("sat_cnt", 32'(redirect_cnt), 32'd3);

    // Halt beats a simultaneous jump, then stays sticky
    halt_in = 1'b1; jmp_req = 1'b1; ihit = 1'b1;
    #2 chk("halt_upd", 32'(updatePC), 32'd0);
    step();
    clr_req();
    #2 chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_jump", jump, 32'h0);
    for (int i = 0; i < 4; i++) begin
      ihit = i[0]; jmp_req = 1'b1; jr_req = i[1];
      #2 chk("halt_sticky_upd", 32'(updatePC), 32'd0);
      step();
    end

    // Reset releases halt
    clr_req(); RST = 1'b1;
    step();
    RST = 1'b0; ihit = 1'b1;
    #2 chk("post_halt_flag", 32'(halted), 32'd0);
    chk("post_halt_upd", 32'(updatePC), 32'd1);
    step();
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
